// File: rtl/y_mat_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : y_mat_pkg
//  Purpose  : Shared constants, FSM state encoding and slot-to-row helper for
//             the Y-matrix row-address extractor.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package y_mat_pkg;

    localparam int SLOTS_PER_WORD = 16;
    localparam int SLOT_W         = 16;
    localparam int WORD_W         = SLOTS_PER_WORD * SLOT_W;   // 256
    localparam int SLOT_IDX_W     = 4;
    localparam int DEF_ADDR_W     = 11;

    // Slots are walked from the top of the word down to slot 0.
    localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_FIN    = 3'd4
    } seq_state_e;

    // Slot k carries row 16-k, except slot 0 which carries row 0.
    function automatic logic [SLOT_W-1:0] slot_to_row(input logic [SLOT_IDX_W-1:0] slot);
        logic [SLOT_W-1:0] row;
        if (slot == '0) begin
            row = '0;
        end else begin
            row = SLOT_W'(SLOTS_PER_WORD) - SLOT_W'(slot);
        end
        return row;
    endfunction

endpackage : y_mat_pkg
`default_nettype wire

// File: rtl/y_idx_slot_mux.sv
`default_nettype none
// ============================================================================
//  Module   : y_idx_slot_mux
//  Purpose  : Combinational slot selector. Picks one 16-bit slot out of a
//             packed index word and derives the Y-matrix row address pair
//             and the row number carried by that slot.
//  Ports    : word_i          256-bit packed index word
//             slot_i          slot number 0..15
//             row_addr_o      low ADDR_W bits of the selected slot
//             row_addr_next_o row_addr_o + 1, wrapping in ADDR_W bits
//             row_idx_o       row number of the selected slot
//  Revision : 1.0  initial release
// ============================================================================
module y_idx_slot_mux
    import y_mat_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [WORD_W-1:0]     word_i,
    input  logic [SLOT_IDX_W-1:0] slot_i,
    output logic [ADDR_W-1:0]     row_addr_o,
    output logic [ADDR_W-1:0]     row_addr_next_o,
    output logic [SLOT_W-1:0]     row_idx_o
);

    logic [SLOTS_PER_WORD-1:0][SLOT_W-1:0] slots_w;
    logic [SLOT_W-1:0]                     field_w;
    // Field bits above ADDR_W are intentionally discarded.
    logic                                  unused_field_w;

    assign slots_w        = word_i;
    assign field_w        = slots_w[slot_i];
    assign unused_field_w = ^field_w;

    always_comb begin
        row_addr_o      = field_w[ADDR_W-1:0];
        // Kept in ADDR_W bits so the top address wraps to zero.
        row_addr_next_o = field_w[ADDR_W-1:0] + ADDR_W'(1);
        row_idx_o       = slot_to_row(slot_i);
    end

endmodule : y_idx_slot_mux
`default_nettype wire

// File: rtl/y_row_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : y_row_addr_sequencer
//  Purpose  : Reads num_words consecutive packed index words starting at
//             base_addr, and for each word streams its 16 slots in row order
//             1..15,0 as (row_addr, row_addr+1) pairs over valid/ready.
//  Ports    : clock_i, reset_i        clock, synchronous active-high reset
//             start_i                 job request (sampled in IDLE only)
//             base_addr_i/num_words_i job parameters, sampled with start_i
//             busy_o, done_o          job status / one-cycle completion pulse
//             idx_rd_en_o/_addr_o     index SRAM read request
//             idx_rd_data_i           index SRAM read data (SRAM_LAT later)
//             row_idx_o, row_addr_o,
//             row_addr_next_o,
//             row_valid_o/row_ready_i downstream row stream
//  Revision : 1.0  initial release
// ============================================================================
module y_row_addr_sequencer
    import y_mat_pkg::*;
#(
    parameter int IDX_AW   = 8,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SRAM_LAT = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [IDX_AW-1:0] base_addr_i,
    input  logic [7:0]        num_words_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              idx_rd_en_o,
    output logic [IDX_AW-1:0] idx_rd_addr_o,
    input  logic [WORD_W-1:0] idx_rd_data_i,
    output logic [SLOT_W-1:0] row_idx_o,
    output logic [ADDR_W-1:0] row_addr_o,
    output logic [ADDR_W-1:0] row_addr_next_o,
    output logic              row_valid_o,
    input  logic              row_ready_i
);

    // Latency counter runs 0..SRAM_LAT-1 inside WAIT.
    localparam int               LAT_W    = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SRAM_LAT - 1);

    seq_state_e              state_q, state_d;
    logic [IDX_AW-1:0]       base_q, base_d;
    logic [7:0]              num_q, num_d;
    logic [7:0]              word_cnt_q, word_cnt_d;
    logic [SLOT_IDX_W-1:0]   slot_q, slot_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [WORD_W-1:0]       word_q, word_d;

    logic [ADDR_W-1:0]       mux_addr_w;
    logic [ADDR_W-1:0]       mux_addr_next_w;
    logic [SLOT_W-1:0]       mux_row_idx_w;

    y_idx_slot_mux #(
        .ADDR_W (ADDR_W)
    ) u_slot_mux (
        .word_i          (word_q),
        .slot_i          (slot_q),
        .row_addr_o      (mux_addr_w),
        .row_addr_next_o (mux_addr_next_w),
        .row_idx_o       (mux_row_idx_w)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            word_cnt_q <= '0;
            slot_q     <= '0;
            lat_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            word_cnt_q <= word_cnt_d;
            slot_q     <= slot_d;
            lat_q      <= lat_d;
            word_q     <= word_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        num_d           = num_q;
        word_cnt_d      = word_cnt_q;
        slot_d          = slot_q;
        lat_d           = lat_q;
        word_d          = word_q;

        busy_o          = 1'b0;
        done_o          = 1'b0;
        idx_rd_en_o     = 1'b0;
        idx_rd_addr_o   = '0;
        row_valid_o     = 1'b0;
        row_idx_o       = '0;
        row_addr_o      = '0;
        row_addr_next_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (num_words_i != 8'd0) begin
                        base_d     = base_addr_i;
                        num_d      = num_words_i;
                        word_cnt_d = 8'd0;
                        state_d    = ST_REQ;
                    end else begin
                        // Empty job: complete without touching the SRAM.
                        state_d    = ST_FIN;
                    end
                end
            end

            ST_REQ: begin
                busy_o        = 1'b1;
                idx_rd_en_o   = 1'b1;
                // Address wraps naturally in IDX_AW bits.
                idx_rd_addr_o = base_q + IDX_AW'(word_cnt_q);
                lat_d         = '0;
                state_d       = ST_WAIT;
            end

            ST_WAIT: begin
                busy_o = 1'b1;
                if (lat_q == LAT_LAST) begin
                    word_d  = idx_rd_data_i;
                    slot_d  = LAST_SLOT;
                    state_d = ST_STREAM;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            ST_STREAM: begin
                busy_o          = 1'b1;
                row_valid_o     = 1'b1;
                row_idx_o       = mux_row_idx_w;
                row_addr_o      = mux_addr_w;
                row_addr_next_o = mux_addr_next_w;
                // Without a transfer nothing moves, so outputs hold stable.
                if (row_ready_i) begin
                    if (slot_q != '0) begin
                        slot_d = slot_q - SLOT_IDX_W'(1);
                    end else if (word_cnt_q == (num_q - 8'd1)) begin
                        state_d = ST_FIN;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                        state_d    = ST_REQ;
                    end
                end
            end

            ST_FIN: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : y_row_addr_sequencer
`default_nettype wire

// File: tb/tb_y_row_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y_row_addr_sequencer
//  Purpose  : Directed self-checking bench for y_row_addr_sequencer. One
//             instance with SRAM_LAT=1 runs the main jobs, a second with
//             SRAM_LAT=3 checks the longer first-row latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_y_row_addr_sequencer;

    logic         clk;
    logic         rst;

    logic         start, busy, done, rd_en, row_valid, ready;
    logic [7:0]   base, nw, rd_addr;
    logic [255:0] rd_data;
    logic [15:0]  row_idx;
    logic [10:0]  row_addr, row_next;

    logic         start3, busy3, done3, rd_en3, row_valid3, ready3;
    logic [7:0]   base3, nw3, rd_addr3;
    logic [255:0] rd_data3;
    logic [15:0]  row_idx3;
    logic [10:0]  row_addr3, row_next3;

    logic [255:0] mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    logic [10:0] first_addr, first_next;

    y_row_addr_sequencer #(.IDX_AW(8), .ADDR_W(11), .SRAM_LAT(1)) dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .start_i         (start),
        .base_addr_i     (base),
        .num_words_i     (nw),
        .busy_o          (busy),
        .done_o          (done),
        .idx_rd_en_o     (rd_en),
        .idx_rd_addr_o   (rd_addr),
        .idx_rd_data_i   (rd_data),
        .row_idx_o       (row_idx),
        .row_addr_o      (row_addr),
        .row_addr_next_o (row_next),
        .row_valid_o     (row_valid),
        .row_ready_i     (ready)
    );

    y_row_addr_sequencer #(.IDX_AW(8), .ADDR_W(11), .SRAM_LAT(3)) dut3 (
        .clock_i         (clk),
        .reset_i         (rst),
        .start_i         (start3),
        .base_addr_i     (base3),
        .num_words_i     (nw3),
        .busy_o          (busy3),
        .done_o          (done3),
        .idx_rd_en_o     (rd_en3),
        .idx_rd_addr_o   (rd_addr3),
        .idx_rd_data_i   (rd_data3),
        .row_idx_o       (row_idx3),
        .row_addr_o      (row_addr3),
        .row_addr_next_o (row_next3),
        .row_valid_o     (row_valid3),
        .row_ready_i     (ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index SRAM models: data is presented for exactly one cycle, SRAM_LAT
    // cycles after the read strobe, so a mistimed capture reads zeros.
    logic         v1_q;
    logic [255:0] d1_q;
    always @(posedge clk) begin
        v1_q <= rd_en;
        d1_q <= mem[rd_addr];
    end
    assign rd_data = v1_q ? d1_q : '0;

    logic [2:0] v3_q;
    logic [7:0] a3_q [3];
    always @(posedge clk) begin
        v3_q    <= {v3_q[1:0], rd_en3};
        a3_q[0] <= rd_addr3;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end
    assign rd_data3 = v3_q[2] ? mem[a3_q[2]] : '0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one job on dut and follow it to done. Expected rows come from
    // the SRAM contents; poke pulses start with other parameters mid-stream.
    task automatic run_job(input logic [7:0] b, input logic [7:0] n, input bit toggle, input bit poke);
        int          cyc, xf, rdc, last, firstv, ei;
        bit          fin, prev_stall;
        logic [7:0]  wa, ea;
        logic [3:0]  sl;
        logic [15:0] fld;
        logic [10:0] en;
        start = 1'b1; base = b; nw = n; ready = 1'b0;
        step();
        cyc = 1; xf = 0; rdc = 0; last = 0; firstv = -1; fin = 0; prev_stall = 0;
        while (!fin && cyc < 3000) begin
            start = 1'b0;
            ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (poke && cyc == 4) begin
                start = 1'b1; base = 8'h55; nw = 8'd7;
            end
            if (cyc == 1) check("busy_after_start", busy, (n != 0));
            if (rd_en) begin
                ea = b + 8'(rdc);
                check("rd_addr", rd_addr, ea);
                rdc++;
            end
            if (prev_stall) check("stall_hold_valid", row_valid, 1);
            if (row_valid) begin
                if (firstv < 0) firstv = cyc;
                wa  = b + 8'(xf / 16);
                sl  = 4'(15 - xf % 16);
                fld = mem[wa][int'(sl)*16 +: 16];
                en  = fld[10:0] + 11'd1;
                ei  = (sl == 4'd0) ? 0 : 16 - int'(sl);
                check("row_idx", row_idx, ei);
                check("row_addr", row_addr, fld[10:0]);
                check("row_next", row_next, en);
                if (xf == 0) begin
                    first_addr = row_addr;
                    first_next = row_next;
                end
                prev_stall = !ready;
                if (ready) begin
                    xf++;
                    last = cyc;
                end
            end else begin
                prev_stall = 0;
            end
            if (done) begin
                fin = 1;
                check("done_xfers", xf, n * 16);
                check("done_timing", cyc, last + 1);
                check("busy_at_done", busy, 0);
            end else begin
                step();
                cyc++;
            end
        end
        start = 1'b0;
        check("job_finished", fin, 1);
        check("rd_count", rdc, n);
        if (n != 0) check("first_valid_lat", firstv, 3);
        step();
        check("done_one_pulse", done, 0);
        check("busy_idle", busy, 0);
        ready = 1'b0;
    endtask

    initial begin
        int xf3;
        for (int a = 0; a < 256; a++) begin
            for (int k = 0; k < 16; k++) begin
                if (a == 'h10) mem[a][k*16 +: 16] = 16'(k * 3);
                else if (a == 'h20 && k == 15) mem[a][k*16 +: 16] = 16'hF7FF;
                else mem[a][k*16 +: 16] = {5'b10110, 11'((a * 97 + k * 29) % 2048)};
            end
        end

        rst = 1'b1; start = 0; base = 0; nw = 0; ready = 0;
        start3 = 0; base3 = 0; nw3 = 0; ready3 = 0;
        repeat (3) step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_valid", row_valid, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_row_addr", row_addr, 0);
        check("rst_row_next", row_next, 0);
        check("rst3_valid", row_valid3, 0);
        check("rst3_busy", busy3, 0);
        rst = 1'b0;
        step();

        // 1: single word, always ready
        run_job(8'h10, 8'd1, 1'b0, 1'b0);
        check("t1_first_addr", first_addr, 11'd45);

        // 2: single word, ready toggling
        run_job(8'h10, 8'd1, 1'b1, 1'b0);

        // 3: three words wrapping the index address, start poked mid-stream
        run_job(8'hFE, 8'd3, 1'b0, 1'b1);

        // 4: top slot field wraps row_addr_next; empty job
        run_job(8'h20, 8'd1, 1'b0, 1'b0);
        check("t4_addr_7ff", first_addr, 11'h7FF);
        check("t4_next_000", first_next, 11'h000);
        run_job(8'h33, 8'd0, 1'b0, 1'b0);

        // 5: reset after the 5th transfer
        start = 1'b1; base = 8'h10; nw = 8'd1;
        step();
        start = 1'b0; ready = 1'b1;
        repeat (7) step();
        check("t5_valid_before", row_valid, 1);
        check("t5_idx_before", row_idx, 6);
        rst = 1'b1;
        step();
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_valid", row_valid, 0);
        check("t5_rd_en", rd_en, 0);
        check("t5_row_idx", row_idx, 0);
        check("t5_row_addr", row_addr, 0);
        check("t5_row_next", row_next, 0);
        rst = 1'b0; ready = 1'b0;
        step();
        check("t5_no_done", done, 0);
        check("t5_idle_busy", busy, 0);
        run_job(8'h10, 8'd1, 1'b0, 1'b0);

        // 6: SRAM_LAT=3 first row at T+5
        start3 = 1'b1; base3 = 8'h10; nw3 = 8'd1; ready3 = 1'b1;
        step();
        start3 = 1'b0;
        check("t6_rd_en", rd_en3, 1);
        check("t6_rd_addr", rd_addr3, 8'h10);
        repeat (3) step();
        check("t6_valid_t4", row_valid3, 0);
        step();
        check("t6_valid_t5", row_valid3, 1);
        check("t6_row_idx", row_idx3, 1);
        check("t6_row_addr", row_addr3, 45);
        check("t6_row_next", row_next3, 46);
        xf3 = 0;
        for (int i = 0; i < 200 && !done3; i++) begin
            if (row_valid3) xf3++;
            step();
        end
        check("t6_done", done3, 1);
        check("t6_xfers", xf3, 16);
        ready3 = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_y_row_addr_sequencer
`default_nettype wire
